alu_mult_seq: RTL

- Sequential unsigned 32x32->64 multiplier (MULTU semantics) that drives the shared ALU as the initiator.
- It acts on the driver side of alu_if: it drives A, B and ALUOP and samples O.
- The ALU performs every add and carry detect; shifting and counting are local.
- Sits beside the datapath and writes HI/LO for MULTU; the datapath stalls while busy is high.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/alu_if.sv | 15 +
 rtl/alu.sv | 39 +++
 rtl/alu_mult_seq.sv | 111 +++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operation codes and the sequential multiplier's state encoding.
package cpu_types_pkg;

  localparam int WORD_W     = 32;
  localparam int MULT_STEPS = 32;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR,  ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [2:0] {IDLE, ADD, CARRY, SHIFT, DONE} multstate_t;

endpackage

// File: rtl/alu_if.sv
// Bundle between an ALU initiator (tb side) and the combinational ALU.
interface alu_if;
  import cpu_types_pkg::*;

  logic [WORD_W-1:0] A;
  logic [WORD_W-1:0] B;
  logic [WORD_W-1:0] O;
  aluop_t            ALUOP;
  logic              N;
  logic              Z;
  logic              V;

  modport tb  (output A, B, ALUOP, input O, N, Z, V);
  modport alu (input A, B, ALUOP, output O, N, Z, V);
endinterface

// File: rtl/alu.sv
// Shared combinational ALU; O follows A/B/ALUOP in the same cycle.
module alu
  import cpu_types_pkg::*;
(
  alu_if.alu aluif
);

  // NOTE: assign every always_comb output before the case so no path infers a latch.
  always_comb begin
    aluif.O = '0;
    aluif.V = 1'b0;
    case (aluif.ALUOP)
      ALU_SLL:  aluif.O = aluif.A << aluif.B[4:0];
      ALU_SRL:  aluif.O = aluif.A >> aluif.B[4:0];
      ALU_SRA:  aluif.O = $signed(aluif.A) >>> aluif.B[4:0];
      ALU_ADD: begin
        aluif.O = aluif.A + aluif.B;
        aluif.V = (aluif.A[WORD_W-1] == aluif.B[WORD_W-1]) &&
                  (aluif.O[WORD_W-1] != aluif.A[WORD_W-1]);
      end
      ALU_SUB: begin
        aluif.O = aluif.A - aluif.B;
        aluif.V = (aluif.A[WORD_W-1] != aluif.B[WORD_W-1]) &&
                  (aluif.O[WORD_W-1] != aluif.A[WORD_W-1]);
      end
      ALU_AND:  aluif.O = aluif.A & aluif.B;
      ALU_OR:   aluif.O = aluif.A | aluif.B;
      ALU_XOR:  aluif.O = aluif.A ^ aluif.B;
      ALU_NOR:  aluif.O = ~(aluif.A | aluif.B);
      ALU_SLT:  aluif.O = {{(WORD_W-1){1'b0}}, $signed(aluif.A) < $signed(aluif.B)};
      ALU_SLTU: aluif.O = {{(WORD_W-1){1'b0}}, aluif.A < aluif.B};
      default:  aluif.O = '0;
    endcase
  end

  assign aluif.N = aluif.O[WORD_W-1];
  assign aluif.Z = (aluif.O == '0);

endmodule

// File: rtl/alu_mult_seq.sv
// Shift-and-add MULTU engine that borrows the shared ALU for every add and carry test.
module alu_mult_seq
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int STEPS = MULT_STEPS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  alu_if.tb                aluif
);

  localparam int CW = $clog2(STEPS);

  multstate_t       state, next_state;
  logic [WIDTH-1:0] m, p_hi, p_lo, sum;
  logic             carry, added;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] nh, shift_hi, shift_lo;
  logic             nc, last_step;

  // The ALU result only replaces HI when this step took the ADD/CARRY path.
  assign nh        = added ? sum : p_hi;
  assign nc        = added & carry;
  assign shift_hi  = {nc, nh[WIDTH-1:1]};
  assign shift_lo  = {nh[0], p_lo[WIDTH-1:1]};
  assign last_step = (count == CW'(STEPS - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    next_state  = state;
    aluif.A     = '0;
    aluif.B     = '0;
    aluif.ALUOP = ALU_ADD;
    case (state)
      IDLE:  if (start) next_state = mplier[0] ? ADD : SHIFT;
      ADD: begin
        aluif.A    = p_hi;
        aluif.B    = m;
        next_state = CARRY;
      end
      CARRY: begin
        aluif.A     = sum;
        aluif.B     = m;
        aluif.ALUOP = ALU_SLTU;
        next_state  = SHIFT;
      end
      SHIFT: begin
        if (last_step)        next_state = DONE;
        else if (shift_lo[0]) next_state = ADD;
        else                  next_state = SHIFT;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      m     <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      added <= 1'b0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (start) begin
          m     <= mcand;
          p_lo  <= mplier;
          p_hi  <= '0;
          count <= '0;
          added <= 1'b0;
        end
        ADD:   sum <= aluif.O;
        CARRY: begin
          carry <= aluif.O[0];
          added <= 1'b1;
        end
        SHIFT: begin
          p_hi  <= shift_hi;
          p_lo  <= shift_lo;
          count <= count + 1'b1;
          added <= 1'b0;
          if (last_step) begin
            hi <= shift_hi;
            lo <= shift_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
